if_axi_prefetch: RTL



---
 rtl/if_axi_prefetch.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/if_axi_prefetch.sv
// Instruction prefetcher: fetches aligned AXI4 INCR bursts into an instruction FIFO
// and presents one instruction at a time to the core over a valid/ready handshake.

`ifndef AXI_ID_IF
`define AXI_ID_IF 4'h1
`endif

module if_axi_prefetch #(
    parameter int                ADDR_W     = 64,
    parameter int                BURST_LEN  = 4,
    parameter int                FIFO_DEPTH = 16,
    parameter logic [ADDR_W-1:0] BASE_PC    = '0,
    parameter int                ID_W       = 4,
    parameter logic [ID_W-1:0]   AXI_ID     = `AXI_ID_IF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_err,
    output logic              stall_if,
    output logic              axi_idle_if,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [ID_W-1:0]   arid,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              rvalid,
    output logic              rready,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic [ID_W-1:0]   rid,
    output logic              awvalid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [ID_W-1:0]   awid,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              wvalid,
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    output logic              wlast,
    output logic              bready
);

    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int PTR_W       = AW + 1;
    localparam int BURST_BYTES = BURST_LEN * 8;
    localparam int OFF_W       = $clog2(BURST_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_fetchPc;
    logic [ADDR_W-1:0] r_araddr;
    logic [ADDR_W-1:0] r_beatAddr;
    logic              r_flushed;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [31:0]       r_memInstr [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_memPc    [FIFO_DEPTH];
    logic              r_memErr   [FIFO_DEPTH];

    logic [PTR_W-1:0]  w_count;
    logic [PTR_W-1:0]  w_free;
    logic [PTR_W-1:0]  w_wptrInc;
    logic              w_empty;
    logic              w_arHs;
    logic              w_rBeat;
    logic              w_accept;
    logic [ADDR_W-1:0] w_hiPc;
    logic              w_pushLo;
    logic              w_pushHi;
    logic [1:0]        w_pushCnt;
    logic              w_pop;
    logic              w_beatErr;
    logic [AW-1:0]     w_rIdx;
    logic [AW-1:0]     w_loIdx;
    logic [AW-1:0]     w_hiIdx;
    logic [ADDR_W-1:0] w_alignedPc;
    logic              w_unused;

    assign w_unused    = ^rid;
    assign w_count     = r_wptr - r_rptr;
    assign w_free      = PTR_W'(FIFO_DEPTH) - w_count;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_wptrInc   = r_wptr + PTR_W'(1);
    assign w_arHs      = arvalid & arready;
    assign w_rBeat     = rvalid & rready;
    assign w_alignedPc = {r_fetchPc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Words below the fetch PC in the first beats of a burst are dropped.
    assign w_accept  = w_rBeat && (r_state == S_DATA) && !redirect_valid;
    assign w_hiPc    = r_beatAddr + ADDR_W'(4);
    assign w_pushLo  = w_accept && (r_beatAddr >= r_fetchPc);
    assign w_pushHi  = w_accept && (w_hiPc >= r_fetchPc);
    assign w_pushCnt = {1'b0, w_pushLo} + {1'b0, w_pushHi};
    assign w_beatErr = (rresp != 2'b00);
    assign w_loIdx   = r_wptr[AW-1:0];
    assign w_hiIdx   = w_pushLo ? w_wptrInc[AW-1:0] : r_wptr[AW-1:0];
    assign w_rIdx    = r_rptr[AW-1:0];
    assign w_pop     = instr_valid & instr_ready;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (!redirect_valid && (w_free >= PTR_W'(2 * BURST_LEN))) w_nextState = S_REQ;
            S_REQ:   if (w_arHs) w_nextState = (r_flushed || redirect_valid) ? S_DRAIN : S_DATA;
            // A final beat coinciding with a redirect still ends the burst.
            S_DATA: begin
                if (w_rBeat && rlast)   w_nextState = S_IDLE;
                else if (redirect_valid) w_nextState = S_DRAIN;
            end
            S_DRAIN: if (w_rBeat && rlast) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetchPc  <= BASE_PC;
            r_araddr   <= '0;
            r_beatAddr <= '0;
            r_flushed  <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state <= w_nextState;
            if (redirect_valid)
                r_fetchPc <= redirect_pc;
            else if ((r_state == S_DATA) && w_rBeat && rlast)
                r_fetchPc <= r_araddr + ADDR_W'(BURST_BYTES);
            if ((r_state == S_IDLE) && (w_nextState == S_REQ)) begin
                r_araddr  <= w_alignedPc;
                r_flushed <= 1'b0;
            end else if ((r_state == S_REQ) && redirect_valid) begin
                r_flushed <= 1'b1;
            end
            if ((r_state == S_REQ) && w_arHs)
                r_beatAddr <= r_araddr;
            else if (w_rBeat)
                r_beatAddr <= r_beatAddr + ADDR_W'(8);
            if (redirect_valid) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                r_wptr <= r_wptr + PTR_W'(w_pushCnt);
                r_rptr <= r_rptr + PTR_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushLo) begin
            r_memInstr[w_loIdx] <= rdata[31:0];
            r_memPc[w_loIdx]    <= r_beatAddr;
            r_memErr[w_loIdx]   <= w_beatErr;
        end
        if (w_pushHi) begin
            r_memInstr[w_hiIdx] <= rdata[63:32];
            r_memPc[w_hiIdx]    <= w_hiPc;
            r_memErr[w_hiIdx]   <= w_beatErr;
        end
    end

    assign instr_valid = !w_empty && !redirect_valid;
    assign instr       = w_empty ? 32'h0 : r_memInstr[w_rIdx];
    assign instr_pc    = w_empty ? '0 : r_memPc[w_rIdx];
    assign instr_err   = w_empty ? 1'b0 : r_memErr[w_rIdx];
    assign stall_if    = !instr_valid;
    assign axi_idle_if = (r_state == S_IDLE);

    assign arvalid = (r_state == S_REQ);
    assign araddr  = r_araddr;
    assign arid    = AXI_ID;
    assign arlen   = 8'(BURST_LEN - 1);
    assign arsize  = 3'd3;
    assign arburst = 2'b01;
    assign rready  = (r_state == S_DATA) || (r_state == S_DRAIN);

    assign awvalid = 1'b0;
    assign awaddr  = '0;
    assign awid    = '0;
    assign awlen   = 8'h0;
    assign awsize  = 3'h0;
    assign awburst = 2'h0;
    assign wvalid  = 1'b0;
    assign wdata   = 64'h0;
    assign wstrb   = 8'h0;
    assign wlast   = 1'b0;
    assign bready  = 1'b0;

endmodule
